// File: rtl/imem_boot_loader.sv
// imem_boot_loader: after reset copies WORDS little-endian words EEPROM->imem, 8 cycles/word with zero-wait acks.
// Holds byte_req/byte_addr until byte_ack (no timeout); done is terminal until reset. Macro BOOT_CHECKSUM_EN adds XOR image check.
module imem_boot_loader #(
    parameter int          WORDS = 64,
    parameter logic [15:0] BASE  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        byte_req,
    output logic [15:0] byte_addr,
    input  logic        byte_ack,
    input  logic [7:0]  byte_data,
    output logic        imem_we,
    output logic [5:0]  imem_wa,
    output logic [31:0] imem_wd,
    output logic        done,
    output logic        checksum_ok
);
    localparam int            CW   = $clog2(WORDS + 1);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GAP,
        WRITE,
`ifdef BOOT_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   addr_q, addr_d;
    logic [1:0]    k_q, k_d;
    logic [31:0]   word_q, word_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]   csum_q, csum_d;
    logic          phase_q, phase_d;
    logic          ok_q, ok_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= BASE;
            k_q     <= 2'd0;
            word_q  <= 32'd0;
            cnt_q   <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q  <= 32'd0;
            phase_q <= 1'b0;
            ok_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            k_q     <= k_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q  <= csum_d;
            phase_q <= phase_d;
            ok_q    <= ok_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        k_d     = k_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d  = csum_q;
        phase_d = phase_q;
        ok_d    = ok_q;
`endif
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (byte_ack) begin
                    word_d[{k_q, 3'b000} +: 8] = byte_data;
                    k_d = k_q + 2'd1;
                    if (k_q != 2'd3) begin
                        state_d = GAP;
`ifdef BOOT_CHECKSUM_EN
                    // last byte of the stored checksum word: compare before it lands in word_q
                    end else if (phase_q) begin
                        state_d = DONE;
                        ok_d    = ({byte_data, word_q[23:0]} == csum_q);
`endif
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            GAP: begin
                addr_d  = addr_q + 16'd1;
                state_d = REQ;
            end
            WRITE: begin
                addr_d = addr_q + 16'd1;
                cnt_d  = cnt_q + CW'(1);
`ifdef BOOT_CHECKSUM_EN
                csum_d = csum_q ^ word_q;
`endif
                if (cnt_q == LAST) begin
`ifdef BOOT_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = REQ;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CHECK: begin
                phase_d = 1'b1;
                state_d = REQ;
            end
`endif
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign byte_req  = (state_q == REQ);
    assign byte_addr = addr_q;
    assign imem_we   = (state_q == WRITE);
    assign imem_wa   = 6'(cnt_q);
    assign imem_wd   = word_q;
    assign done      = (state_q == DONE);
`ifdef BOOT_CHECKSUM_EN
    assign checksum_ok = ok_q;
`else
    assign checksum_ok = done;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: two instances (BASE=0/WORDS=64 and BASE=FFFC/WORDS=2) against a byte-array EEPROM model.
module tb_imem_boot_loader;
    localparam int          W0 = 64;
    localparam logic [15:0] B0 = 16'h0000;
    localparam int          W1 = 2;
    localparam logic [15:0] B1 = 16'hFFFC;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2] = '{1'b0, 1'b0};
    logic        req   [2];
    logic [15:0] addr  [2];
    logic        ack   [2];
    logic [7:0]  dat   [2];
    logic        we    [2];
    logic [5:0]  wa    [2];
    logic [31:0] wd    [2];
    logic        done  [2];
    logic        ok    [2];

    imem_boot_loader #(.WORDS(W0), .BASE(B0)) dut0 (
        .clk(clk), .reset_n(rst_n[0]), .byte_req(req[0]), .byte_addr(addr[0]),
        .byte_ack(ack[0]), .byte_data(dat[0]), .imem_we(we[0]), .imem_wa(wa[0]),
        .imem_wd(wd[0]), .done(done[0]), .checksum_ok(ok[0])
    );
    imem_boot_loader #(.WORDS(W1), .BASE(B1)) dut1 (
        .clk(clk), .reset_n(rst_n[1]), .byte_req(req[1]), .byte_addr(addr[1]),
        .byte_ack(ack[1]), .byte_data(dat[1]), .imem_we(we[1]), .imem_wa(wa[1]),
        .imem_wd(wd[1]), .done(done[1]), .checksum_ok(ok[1])
    );

    logic [7:0]  eeprom [65536];
    int          lat [2] = '{0, 0};
    int          spur [2] = '{0, 0};
    int          waitc [2];
    int          cyc [2];
    int          done_cyc [2];
    int          acc_n [2];
    int          wr_n [2];
    logic [15:0] acc_a [2][1024];
    logic [5:0]  wr_a [2][128];
    logic [31:0] wr_d [2][128];
    int          wr_c [2][128];

    int total = 0;
    int bad   = 0;

    // EEPROM responder and write/address recorder; cycle 0 is the first cycle after reset release
    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (!rst_n[j]) begin
                cyc[j] = -1; waitc[j] = 0; acc_n[j] = 0; wr_n[j] = 0; done_cyc[j] = -1;
                ack[j] = 1'b0; dat[j] = 8'h00;
            end else begin
                cyc[j]++;
                if (we[j]) begin
                    if (wr_n[j] < 128) begin
                        wr_a[j][wr_n[j]] = wa[j];
                        wr_d[j][wr_n[j]] = wd[j];
                        wr_c[j][wr_n[j]] = cyc[j];
                    end
                    wr_n[j]++;
                end
                if (done[j] && done_cyc[j] < 0) done_cyc[j] = cyc[j];
                if (req[j]) begin
                    if (waitc[j] >= lat[j]) begin
                        ack[j] = 1'b1;
                        dat[j] = eeprom[addr[j]];
                        if (acc_n[j] < 1024) acc_a[j][acc_n[j]] = addr[j];
                        acc_n[j]++;
                        waitc[j] = 0;
                    end else begin
                        ack[j] = 1'b0;
                        waitc[j]++;
                    end
                end else begin
                    waitc[j] = 0;
                    ack[j] = (spur[j] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    dat[j] = 8'($urandom);
                end
            end
        end
    end

    function automatic logic [31:0] exp_word(input logic [15:0] base, input int i);
        logic [31:0] w;
        logic [15:0] a;
        for (int k = 0; k < 4; k++) begin
            a = base + 16'(4 * i + k);
            w[8*k +: 8] = eeprom[a];
        end
        return w;
    endfunction

    function automatic int exp_done(input int words, input int l);
        int d;
        d = 1 + words * (4 * l + 8);
        if (CSUM) d = d + 4 * l + 8;
        return d;
    endfunction

    function automatic int exp_naddr(input int words);
        return 4 * words + (CSUM ? 4 : 0);
    endfunction

    function automatic logic exp_ok(input logic [15:0] base, input int words);
        logic [31:0] x;
        if (!CSUM) return 1'b1;
        x = 32'd0;
        for (int i = 0; i < words; i++) x = x ^ exp_word(base, i);
        return exp_word(base, words) == x;
    endfunction

    task automatic put_word(input logic [15:0] a, input logic [31:0] w);
        logic [15:0] ak;
        for (int k = 0; k < 4; k++) begin
            ak = a + 16'(k);
            eeprom[ak] = w[8*k +: 8];
        end
    endtask

    task automatic start(input int j, input int l, input int s);
        rst_n[j] = 1'b0;
        lat[j] = l;
        spur[j] = s;
        repeat (2) @(posedge clk);
        #2 rst_n[j] = 1'b1;
    endtask

    task automatic wait_done(input int j, input int bound, output bit to);
        to = 1'b1;
        for (int c = 0; c < bound; c++) begin
            @(posedge clk);
            if (done_cyc[j] >= 0) begin
                to = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int j = 0; j < 2; j++) begin
            total++;
            if (req[j] !== 1'b0 || we[j] !== 1'b0 || done[j] !== 1'b0 || ok[j] !== 1'b0) begin
                bad++;
                $display("FAIL reset_ctrl[%0d] req=%b we=%b done=%b ok=%b expected all 0", j, req[j], we[j], done[j], ok[j]);
            end
            total++;
            if (addr[j] !== ((j == 0) ? B0 : B1)) begin
                bad++;
                $display("FAIL reset_addr[%0d] got %h", j, addr[j]);
            end
            total++;
            if (wa[j] !== 6'd0 || wd[j] !== 32'd0) begin
                bad++;
                $display("FAIL reset_imem[%0d] wa=%0d wd=%h expected 0/0", j, wa[j], wd[j]);
            end
        end
    endtask

    task automatic test_zero_wait();
        bit to;
        start(0, 0, 0);
        @(negedge clk); #1;
        total++;
        if (req[0] !== 1'b0) begin bad++; $display("FAIL idle_cycle req=%b expected 0", req[0]); end
        @(negedge clk); #1;
        total++;
        if (req[0] !== 1'b1 || addr[0] !== B0) begin
            bad++; $display("FAIL first_req req=%b addr=%h expected 1/%h", req[0], addr[0], B0);
        end
        wait_done(0, 3000, to);
        total++;
        if (to) begin bad++; $display("FAIL zw_timeout done never rose"); end
        total++;
        if (done_cyc[0] != exp_done(W0, 0)) begin
            bad++; $display("FAIL zw_done_cycle got %0d expected %0d", done_cyc[0], exp_done(W0, 0));
        end
        total++;
        if (wr_n[0] != W0) begin bad++; $display("FAIL zw_write_count got %0d expected %0d", wr_n[0], W0); end
        total++;
        if (wr_a[0][0] !== 6'd0 || wr_d[0][0] !== 32'h00500513) begin
            bad++; $display("FAIL zw_first_write wa=%0d wd=%h expected 0/00500513", wr_a[0][0], wr_d[0][0]);
        end
        for (int i = 0; i < W0; i++) begin
            total++;
            if (wr_a[0][i] !== 6'(i) || wr_d[0][i] !== exp_word(B0, i) || wr_c[0][i] != 8 + i * 8) begin
                bad++;
                $display("FAIL zw_word[%0d] wa=%0d wd=%h cyc=%0d expected %0d/%h/%0d", i, wr_a[0][i], wr_d[0][i],
                         wr_c[0][i], i, exp_word(B0, i), 8 + i * 8);
            end
        end
        total++;
        if (acc_n[0] != exp_naddr(W0)) begin
            bad++; $display("FAIL zw_byte_count got %0d expected %0d", acc_n[0], exp_naddr(W0));
        end
        total++;
        if (done[0] !== 1'b1 || ok[0] !== exp_ok(B0, W0) || req[0] !== 1'b0 || we[0] !== 1'b0) begin
            bad++; $display("FAIL zw_final done=%b ok=%b req=%b we=%b expected 1/%b/0/0", done[0], ok[0], req[0],
                            we[0], exp_ok(B0, W0));
        end
    endtask

    task automatic test_ack_latency();
        bit to;
        start(0, 3, 0);
        wait_done(0, 3000, to);
        total++;
        if (to) begin bad++; $display("FAIL lat_timeout done never rose"); end
        total++;
        if (done_cyc[0] != exp_done(W0, 3)) begin
            bad++; $display("FAIL lat_done_cycle got %0d expected %0d", done_cyc[0], exp_done(W0, 3));
        end
        for (int i = 0; i < W0; i++) begin
            total++;
            if (wr_d[0][i] !== exp_word(B0, i) || wr_c[0][i] != 20 + i * 20) begin
                bad++; $display("FAIL lat_word[%0d] wd=%h cyc=%0d expected %h/%0d", i, wr_d[0][i], wr_c[0][i],
                                exp_word(B0, i), 20 + i * 20);
            end
        end
    endtask

    task automatic test_spurious_ack();
        bit to;
        start(0, 1, 1);
        wait_done(0, 3000, to);
        total++;
        if (to) begin bad++; $display("FAIL spur_timeout done never rose"); end
        total++;
        if (acc_n[0] != exp_naddr(W0) || wr_n[0] != W0 || done_cyc[0] != exp_done(W0, 1)) begin
            bad++; $display("FAIL spur_counts bytes=%0d writes=%0d done=%0d expected %0d/%0d/%0d", acc_n[0],
                            wr_n[0], done_cyc[0], exp_naddr(W0), W0, exp_done(W0, 1));
        end
        for (int i = 0; i < exp_naddr(W0); i++) begin
            total++;
            if (acc_a[0][i] !== B0 + 16'(i)) begin
                bad++; $display("FAIL spur_addr[%0d] got %h expected %h", i, acc_a[0][i], B0 + 16'(i));
            end
        end
        for (int i = 0; i < W0; i++) begin
            total++;
            if (wr_d[0][i] !== exp_word(B0, i)) begin
                bad++; $display("FAIL spur_word[%0d] got %h expected %h", i, wr_d[0][i], exp_word(B0, i));
            end
        end
    endtask

    task automatic test_mid_reset();
        bit to;
        start(0, 0, 0);
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #2;
            if (acc_n[0] >= 22) break;
        end
        total++;
        if (acc_n[0] != 22) begin bad++; $display("FAIL mid_sync bytes=%0d expected 22", acc_n[0]); end
        @(posedge clk); #2;
        total++;
        if (req[0] !== 1'b1 || addr[0] !== B0 + 16'd22 || wr_n[0] != 5) begin
            bad++; $display("FAIL mid_pre_reset req=%b addr=%h writes=%0d expected 1/%h/5", req[0], addr[0],
                            wr_n[0], B0 + 16'd22);
        end
        rst_n[0] = 1'b0;
        #1;
        total++;
        if (req[0] !== 1'b0 || addr[0] !== B0 || we[0] !== 1'b0 || wa[0] !== 6'd0 || wd[0] !== 32'd0 ||
            done[0] !== 1'b0 || ok[0] !== 1'b0) begin
            bad++; $display("FAIL mid_async_reset req=%b addr=%h we=%b wa=%0d wd=%h done=%b ok=%b", req[0],
                            addr[0], we[0], wa[0], wd[0], done[0], ok[0]);
        end
        repeat (2) @(posedge clk);
        #2 rst_n[0] = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        total++;
        if (req[0] !== 1'b1 || addr[0] !== B0) begin
            bad++; $display("FAIL mid_restart req=%b addr=%h expected 1/%h", req[0], addr[0], B0);
        end
        wait_done(0, 3000, to);
        total++;
        if (to || wr_n[0] != W0) begin
            bad++; $display("FAIL mid_reload timeout=%b writes=%0d expected 0/%0d", to, wr_n[0], W0);
        end
        for (int i = 0; i < W0; i++) begin
            total++;
            if (wr_a[0][i] !== 6'(i) || wr_d[0][i] !== exp_word(B0, i)) begin
                bad++; $display("FAIL mid_word[%0d] wa=%0d wd=%h expected %0d/%h", i, wr_a[0][i], wr_d[0][i], i,
                                exp_word(B0, i));
            end
        end
    endtask

    task automatic test_addr_wrap();
        bit to;
        int l;
        logic [15:0] a;
        for (int k = 0; k < 12; k++) begin
            a = B1 + 16'(k);
            eeprom[a] = 8'($urandom);
        end
        l = int'($urandom_range(0, 2));
        start(1, l, 1);
        wait_done(1, 500, to);
        total++;
        if (to || done_cyc[1] != exp_done(W1, l)) begin
            bad++; $display("FAIL wrap_done timeout=%b cyc=%0d expected %0d", to, done_cyc[1], exp_done(W1, l));
        end
        total++;
        if (acc_n[1] != exp_naddr(W1) || wr_n[1] != W1) begin
            bad++; $display("FAIL wrap_counts bytes=%0d writes=%0d expected %0d/%0d", acc_n[1], wr_n[1],
                            exp_naddr(W1), W1);
        end
        total++;
        if (acc_a[1][3] !== 16'hFFFF || acc_a[1][4] !== 16'h0000) begin
            bad++; $display("FAIL wrap_edge got %h,%h expected ffff,0000", acc_a[1][3], acc_a[1][4]);
        end
        for (int i = 0; i < exp_naddr(W1); i++) begin
            total++;
            if (acc_a[1][i] !== B1 + 16'(i)) begin
                bad++; $display("FAIL wrap_addr[%0d] got %h expected %h", i, acc_a[1][i], B1 + 16'(i));
            end
        end
        for (int i = 0; i < W1; i++) begin
            total++;
            if (wr_a[1][i] !== 6'(i) || wr_d[1][i] !== exp_word(B1, i)) begin
                bad++; $display("FAIL wrap_word[%0d] wa=%0d wd=%h expected %0d/%h", i, wr_a[1][i], wr_d[1][i], i,
                                exp_word(B1, i));
            end
        end
        total++;
        if (ok[1] !== exp_ok(B1, W1)) begin
            bad++; $display("FAIL wrap_ok got %b expected %b", ok[1], exp_ok(B1, W1));
        end
    endtask

    task automatic test_checksum();
        bit to;
`ifdef BOOT_CHECKSUM_EN
        for (int v = 0; v < 2; v++) begin
            put_word(16'hFFFC, 32'h11111111);
            put_word(16'h0000, 32'h22222222);
            put_word(16'h0004, 32'h33333333 + 32'(v));
            start(1, v, 0);
            wait_done(1, 500, to);
            total++;
            if (to || done[1] !== 1'b1 || ok[1] !== (v == 0)) begin
                bad++; $display("FAIL csum_case%0d timeout=%b done=%b ok=%b expected 0/1/%b", v, to, done[1], ok[1],
                                v == 0);
            end
        end
`else
        put_word(16'hFFFC, 32'h11111111);
        put_word(16'h0000, 32'h22222222);
        start(1, 0, 0);
        repeat (6) @(negedge clk);
        #1;
        total++;
        if (ok[1] !== 1'b0 || done[1] !== 1'b0) begin
            bad++; $display("FAIL csum_busy ok=%b done=%b expected 0/0", ok[1], done[1]);
        end
        wait_done(1, 500, to);
        total++;
        if (to || ok[1] !== 1'b1 || done[1] !== 1'b1) begin
            bad++; $display("FAIL csum_follows_done timeout=%b ok=%b done=%b expected 0/1/1", to, ok[1], done[1]);
        end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 65536; a++) eeprom[a] = 8'($urandom);
        put_word(16'h0000, 32'h00500513);
        test_reset();
        test_zero_wait();
        test_ack_latency();
        test_spurious_ack();
        test_mid_reset();
        test_addr_wrap();
        test_checksum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 The block SHALL have parameter WORDS, default 64, giving the number of 32-bit instruction words copied into imem.
REQ-002 The block SHALL have parameter BASE, default 16'h0000, giving the first EEPROM byte address read.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on posedge clk.
REQ-004 The block SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port byte_req, output, 1, high while requesting the byte at byte_addr.
REQ-006 The block SHALL have port byte_addr, output, 16, the EEPROM byte address.
REQ-007 The block SHALL have port byte_ack, input, 1, a one-cycle pulse meaning byte_data is valid for the current byte_addr.
REQ-008 The block SHALL have port byte_data, input, 8, the EEPROM read data, sampled only when byte_req and byte_ack are both high.
REQ-009 The block SHALL have port imem_we, output, 1, the imem write enable.
REQ-010 The block SHALL have port imem_wa, output, 6, the imem word index.
REQ-011 The block SHALL have port imem_wd, output, 32, the imem write data.
REQ-012 The block SHALL have port done, output, 1, meaning the load is complete and the CPU may leave reset.
REQ-013 The block SHALL have port checksum_ok, output, 1, meaning the image checksum passed.

Function
REQ-014 The state machine SHALL have states IDLE, REQ, GAP, WRITE, CHECK and DONE.
REQ-015 After reset release the block SHALL spend exactly one cycle in IDLE, then enter REQ with byte_addr = BASE.
REQ-016 In REQ, byte_req SHALL be 1 and SHALL stay high until byte_ack; there is no timeout.
REQ-017 byte_ack SHALL be ignored whenever byte_req is 0 (GAP, WRITE, CHECK, DONE, IDLE).
REQ-018 On an accepted byte the block SHALL store byte_data little-endian: byte index k = 0..3 goes to word bits [8k+7:8k].
REQ-019 After an accepted byte with k < 3 the block SHALL spend one cycle in GAP with byte_req = 0, increment byte_addr by 1, then return to REQ.
REQ-020 After an accepted byte with k = 3 the block SHALL spend one cycle in WRITE: imem_we = 1, imem_wa = word count, imem_wd = the assembled word, byte_addr incremented by 1.
REQ-021 imem_we SHALL be high only in WRITE, for exactly one cycle per word.
REQ-022 After the WRITE for word index WORDS-1 the block SHALL go to CHECK if BOOT_CHECKSUM_EN is defined, otherwise to DONE; otherwise it SHALL return to REQ.
REQ-023 With zero-wait acks, one word SHALL take 8 cycles (REQ,GAP,REQ,GAP,REQ,GAP,REQ,WRITE), so done rises 1+8*WORDS cycles after reset release.
REQ-024 done SHALL be 1 only in DONE; DONE is terminal until reset, with byte_req = 0 and imem_we = 0.
REQ-025 The word counter SHALL be wide enough for WORDS, and imem_wa SHALL be its low 6 bits.
REQ-026 byte_addr SHALL wrap modulo 2^16 without error.

Reset
REQ-027 Asserting reset_n low SHALL, asynchronously and at any point (including mid-word), force IDLE.
REQ-028 Reset SHALL set byte_req = 0, byte_addr = BASE, imem_we = 0, imem_wa = 0, imem_wd = 0, done = 0, checksum_ok = 0, and clear all counters, the assembly register and the checksum.
REQ-029 After reset release the load SHALL restart from word 0; a partial word SHALL never be written.

Configuration
REQ-030 Macro BOOT_CHECKSUM_EN SHALL enable the checksum feature.
REQ-031 With BOOT_CHECKSUM_EN defined, each written word SHALL be XORed into a 32-bit running checksum that is initially 0.
REQ-032 With BOOT_CHECKSUM_EN defined, CHECK SHALL read 4 further bytes at BASE+4*WORDS using the REQ/GAP handshake, with no imem write.
REQ-033 With BOOT_CHECKSUM_EN defined, checksum_ok SHALL be registered in DONE as (stored word == running checksum).
REQ-034 With BOOT_CHECKSUM_EN defined, done SHALL assert regardless of the checksum_ok result.
REQ-035 Without BOOT_CHECKSUM_EN, there SHALL be no CHECK state or checksum logic, and checksum_ok SHALL equal done.

Verification
REQ-036 Zero-wait acks, WORDS=64, EEPROM holding bytes 13,05,50,00 at 0..3 -> first WRITE: imem_wa=0, imem_wd=32'h00500513; done rises at cycle 513 (macro off).
REQ-037 3-cycle ack latency per byte -> imem_wd values unchanged and each word takes 20 cycles.
REQ-038 Spurious byte_ack pulse during GAP -> ignored; byte_addr advances by exactly 1 per accepted byte.
REQ-039 reset_n low while k=2 of word 5 -> outputs reach reset values immediately; after release, first request is at BASE and word 0 is rewritten.
REQ-040 BOOT_CHECKSUM_EN, WORDS=2, words 32'h11111111 and 32'h22222222, stored word 32'h33333333 -> done=1, checksum_ok=1; stored word 32'h33333334 -> done=1, checksum_ok=0.
REQ-041 BASE=16'hFFFC, WORDS=2 -> byte_addr sequence FFFC..FFFF, 0000..0003, wrapping correctly.
